// File: rtl/oisc8_pkg.sv
// ---------------------------------------------------------------------------
// oisc8_pkg
// Shared definitions for the OISC8 communication-interface responders.
//   - com address map constants (0x00 means "no access")
//   - uart_state_t, the state encoding used by both UART FSMs
//   - bit positions inside the STATUS register
//   - eff_div(): clamps a programmed divisor to the smallest usable value
// ---------------------------------------------------------------------------
package oisc8_pkg;

  localparam logic [7:0] COM_NONE   = 8'h00;
  localparam logic [7:0] COM_TXDATA = 8'h01;
  localparam logic [7:0] COM_RXDATA = 8'h02;
  localparam logic [7:0] COM_STATUS = 8'h03;
  localparam logic [7:0] COM_CTRL   = 8'h04;
  localparam logic [7:0] COM_DIVLO  = 8'h05;
  localparam logic [7:0] COM_DIVHI  = 8'h06;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int STAT_RX_NEMPTY = 0;
  localparam int STAT_TX_FULL   = 1;
  localparam int STAT_TX_BUSY   = 2;
  localparam int STAT_TX_OVF    = 3;
  localparam int STAT_RX_OVF    = 4;
  localparam int STAT_RX_FERR   = 5;

  // A bit period shorter than two clocks leaves no room for a half-bit
  // sample point, so 0 and 1 behave like 2.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    if (div < 16'd2) begin
      return 16'd2;
    end
    return div;
  endfunction

endpackage

// File: rtl/com_fifo.sv
// ---------------------------------------------------------------------------
// com_fifo
// Synchronous first-word-fall-through FIFO used for the UART TX and RX queues.
//   clk    in  system clock
//   rst    in  synchronous active-low reset (empties the FIFO)
//   push   in  write din this cycle (accepted when not full, or when full
//              and a pop happens in the same cycle)
//   pop    in  advance past the head entry (ignored when empty)
//   din    in  WIDTH-bit write data
//   dout   out head entry, valid while empty = 0
//   full   out DEPTH entries stored
//   empty  out no entries stored
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module com_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push
  // when it is also being popped.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/oisc_com_uart.sv
// ---------------------------------------------------------------------------
// oisc_com_uart
// 8N1 UART responder on the OISC8 com interface. The CPU com block drives
// com_addr/com_wr; every cycle with a matching address is one access.
//   clk       in  system clock
//   rst       in  synchronous active-low reset
//   com_addr  in  register address, 0x00 when the initiator is idle
//   com_wr    in  write data for TXDATA/CTRL/DIVLO/DIVHI
//   com_rd    out read data (RXDATA, STATUS), combinational; 0 otherwise
//   uart_tx   out serial output, idle high
//   uart_rx   in  serial input, asynchronous to clk
// Register map: 0x01 TXDATA(W) 0x02 RXDATA(R, pops) 0x03 STATUS(R)
//               0x04 CTRL(W, bit0 clears flags) 0x05 DIVLO(W) 0x06 DIVHI(W)
// STATUS = {2'b0, rx_ferr, rx_ovf, tx_ovf, tx_busy, tx_full, rx_nempty}
// ---------------------------------------------------------------------------
module oisc_com_uart
  import oisc8_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] com_addr,
  input  logic [7:0] com_wr,
  output logic [7:0] com_rd,
  output logic       uart_tx,
  input  logic       uart_rx
);

  // Register decode
  logic wr_txdata;
  logic rd_rxdata;
  logic wr_ctrl_clr;

  assign wr_txdata   = (com_addr == COM_TXDATA);
  assign rd_rxdata   = (com_addr == COM_RXDATA);
  assign wr_ctrl_clr = (com_addr == COM_CTRL) && com_wr[0];

  // Bit-period divisor. Counters reload from div_last at every bit boundary,
  // so a new divisor only takes effect on the next reload.
  logic [15:0] div_reg;
  logic [15:0] div_eff;
  logic [15:0] div_last;
  logic [15:0] half_last;

  assign div_eff   = eff_div(div_reg);
  assign div_last  = div_eff - 16'd1;
  assign half_last = (div_eff >> 1) - 16'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_reg <= DIV_RESET;
    end else if (com_addr == COM_DIVLO) begin
      div_reg[7:0] <= com_wr;
    end else if (com_addr == COM_DIVHI) begin
      div_reg[15:8] <= com_wr;
    end
  end

  // FIFOs
  logic       tx_pop;
  logic [7:0] tx_dout;
  logic       tx_full;
  logic       tx_empty;

  logic       rx_push;
  logic [7:0] rx_dout;
  logic       rx_full;
  logic       rx_empty;

  com_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txdata),
    .pop   (tx_pop),
    .din   (com_wr),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  logic [7:0] rx_shift;

  com_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rd_rxdata),
    .din   (rx_shift),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // TX serializer
  uart_state_t tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_busy;

  assign tx_pop  = (tx_state == IDLE) && !tx_empty;
  assign tx_busy = !tx_empty || (tx_state != IDLE);

  // uart_tx is registered; each state entry sets the level for the bit that
  // starts on that edge, and tx_cnt counts down the clocks of that bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (!tx_empty) begin
            tx_shift <= tx_dout;
            tx_cnt   <= div_last;
            uart_tx  <= 1'b0;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt   <= div_last;
            tx_bit   <= 3'd0;
            uart_tx  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_state <= DATA;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        DATA: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt <= div_last;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              uart_tx  <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        STOP: begin
          if (tx_cnt == 16'd0) begin
            tx_state <= IDLE;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        default: begin
          tx_state <= IDLE;
          uart_tx  <= 1'b1;
        end
      endcase
    end
  end

  // RX synchronizer plus one extra stage for falling-edge detection.
  // All three reset high so a released reset never looks like a start bit.
  logic rx_s1;
  logic rx_s2;
  logic rx_prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX deserializer
  uart_state_t rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic        rx_stop_done;
  logic        rx_ferr_set;

  assign rx_stop_done = (rx_state == STOP) && (rx_cnt == 16'd0);
  assign rx_push      = rx_stop_done && rx_s2;
  assign rx_ferr_set  = rx_stop_done && !rx_s2;

  // The first wait is half a bit so every later sample (spaced one full bit
  // apart) lands near the middle of its bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= half_last;
            rx_state <= START;
          end
        end
        START: begin
          if (rx_cnt == 16'd0) begin
            if (!rx_s2) begin
              rx_cnt   <= div_last;
              rx_bit   <= 3'd0;
              rx_state <= DATA;
            end else begin
              rx_state <= IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        DATA: begin
          if (rx_cnt == 16'd0) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= div_last;
            if (rx_bit == 3'd7) begin
              rx_state <= STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        STOP: begin
          if (rx_cnt == 16'd0) begin
            rx_state <= IDLE;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        default: begin
          rx_state <= IDLE;
        end
      endcase
    end
  end

  // Sticky error flags. A set in the same cycle as a CTRL clear survives.
  logic tx_ovf;
  logic rx_ovf;
  logic rx_ferr;
  logic tx_ovf_set;
  logic rx_ovf_set;

  assign tx_ovf_set = wr_txdata && tx_full && !tx_pop;
  assign rx_ovf_set = rx_push && rx_full && !rd_rxdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_ovf  <= 1'b0;
      rx_ovf  <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      tx_ovf  <= tx_ovf_set  || (tx_ovf  && !wr_ctrl_clr);
      rx_ovf  <= rx_ovf_set  || (rx_ovf  && !wr_ctrl_clr);
      rx_ferr <= rx_ferr_set || (rx_ferr && !wr_ctrl_clr);
    end
  end

  // Read mux
  logic [7:0] status;

  always_comb begin
    status                 = 8'h00;
    status[STAT_RX_NEMPTY] = !rx_empty;
    status[STAT_TX_FULL]   = tx_full;
    status[STAT_TX_BUSY]   = tx_busy;
    status[STAT_TX_OVF]    = tx_ovf;
    status[STAT_RX_OVF]    = rx_ovf;
    status[STAT_RX_FERR]   = rx_ferr;
  end

  always_comb begin
    com_rd = 8'h00;
    if (rst) begin
      case (com_addr)
        COM_RXDATA: com_rd = rx_empty ? 8'h00 : rx_dout;
        COM_STATUS: com_rd = status;
        default:    com_rd = 8'h00;
      endcase
    end
  end

endmodule
